sync_wstage_fifo: RTL and testbench

SYNC_WSTAGE_FIFO -- requirements
Module: sync_wstage_fifo

---
 rtl/sync_wstage_fifo.sv | 164 ++++++++++++++++
 tb/tb_sync_wstage_fifo.sv | 312 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sync_wstage_fifo.sv
// sync_wstage_fifo
// ----------------
// Synchronous FIFO built around one single-port RAM. Every accepted word
// moves through three places, in order:
//   small register staging FIFO -> RAM -> small register output buffer.
// One RAM access (read or write) happens per cycle, so sustained throughput
// is at most one word every two cycles. The RAM read pipeline is 1 cycle.
// From acceptance to out_valid the minimum latency is 4 cycles.
//
// Ports
//   clk        clock; all state changes on the rising edge
//   rstn       synchronous active-low reset
//   in_data    write data
//   in_valid   write request
//   in_ready   FIFO can accept a word (depends only on registered count)
//   out_data   head-of-queue data
//   out_valid  out_data is valid
//   out_ready  consumer takes the word
//   clear      synchronous flush, same effect as reset
//   count      words accepted and not yet delivered
module sync_wstage_fifo #(
    parameter int DATA_WIDTH = 8,
    parameter int FIFO_DEPTH = 256
) (
    input  logic                          clk,
    input  logic                          rstn,
    input  logic [DATA_WIDTH-1:0]         in_data,
    input  logic                          in_valid,
    output logic                          in_ready,
    output logic [DATA_WIDTH-1:0]         out_data,
    output logic                          out_valid,
    input  logic                          out_ready,
    input  logic                          clear,
    output logic [$clog2(FIFO_DEPTH):0]   count
);

    localparam int LB          = $clog2(FIFO_DEPTH);
    localparam int STAGE_DEPTH = 4;
    localparam int OUT_DEPTH   = 4;

    // Write staging FIFO
    logic [DATA_WIDTH-1:0] stage_mem [STAGE_DEPTH];
    logic [1:0]            stage_head;
    logic [1:0]            stage_tail;
    logic [2:0]            stage_count;

    // RAM and its pointers
    logic [DATA_WIDTH-1:0] ram [FIFO_DEPTH];
    logic [DATA_WIDTH-1:0] ram_q;
    logic [LB-1:0]         waddr;
    logic [LB-1:0]         raddr;
    logic [LB-1:0]         ram_addr;
    logic [LB:0]           mem_count;
    logic                  rd_valid;

    // Output buffer
    logic [DATA_WIDTH-1:0] obuf [OUT_DEPTH];
    logic [1:0]            out_head;
    logic [1:0]            out_tail;
    logic [2:0]            out_count;

    logic in_exec;
    logic out_exec;
    logic wr_ok;
    logic rd_ok;
    logic do_write;
    logic do_read;

    assign in_ready  = (count < (LB+1)'(FIFO_DEPTH));
    assign out_valid = (out_count != 3'd0);
    assign out_data  = obuf[out_head];
    assign in_exec   = in_valid & in_ready;
    assign out_exec  = out_valid & out_ready;

    // A read is only issued when the output buffer is guaranteed a free
    // slot for it, counting the read that may already be in flight.
    assign wr_ok = (stage_count != 3'd0);
    assign rd_ok = (mem_count != '0) &&
                   ((out_count + 3'(rd_valid)) < 3'(OUT_DEPTH));

    // A full staging FIFO forces a write so the next accepted word always
    // finds room; otherwise reads win to keep the output side fed.
    assign do_write = wr_ok && ((stage_count == 3'(STAGE_DEPTH)) || !rd_ok);
    assign do_read  = !do_write && rd_ok;
    assign ram_addr = do_write ? waddr : raddr;

    // Single-port RAM: one address, either written or read each cycle.
    always_ff @(posedge clk) begin
        if (do_write) begin
            ram[ram_addr] <= stage_mem[stage_head];
        end else if (do_read) begin
            ram_q <= ram[ram_addr];
        end
    end

    // Data storage of the register FIFOs; pointers are flushed separately,
    // so stale contents here are never observed.
    always_ff @(posedge clk) begin
        if (in_exec) begin
            stage_mem[stage_tail] <= in_data;
        end
        if (rd_valid) begin
            obuf[out_tail] <= ram_q;
        end
    end

    // Control state: occupancy counters, pointers and the read-valid delay.
    // Clearing rd_valid drops any RAM read in flight.
    always_ff @(posedge clk) begin
        if (!rstn || clear) begin
            count       <= '0;
            stage_head  <= 2'd0;
            stage_tail  <= 2'd0;
            stage_count <= 3'd0;
            waddr       <= '0;
            raddr       <= '0;
            mem_count   <= '0;
            rd_valid    <= 1'b0;
            out_head    <= 2'd0;
            out_tail    <= 2'd0;
            out_count   <= 3'd0;
        end else begin
            case ({in_exec, out_exec})
                2'b10:   count <= count + (LB+1)'(1);
                2'b01:   count <= count - (LB+1)'(1);
                default: count <= count;
            endcase

            if (in_exec) begin
                stage_tail <= stage_tail + 2'd1;
            end
            if (do_write) begin
                stage_head <= stage_head + 2'd1;
            end
            case ({in_exec, do_write})
                2'b10:   stage_count <= stage_count + 3'd1;
                2'b01:   stage_count <= stage_count - 3'd1;
                default: stage_count <= stage_count;
            endcase

            if (do_write) begin
                waddr     <= waddr + LB'(1);
                mem_count <= mem_count + (LB+1)'(1);
            end else if (do_read) begin
                raddr     <= raddr + LB'(1);
                mem_count <= mem_count - (LB+1)'(1);
            end
            rd_valid <= do_read;

            if (rd_valid) begin
                out_tail <= out_tail + 2'd1;
            end
            if (out_exec) begin
                out_head <= out_head + 2'd1;
            end
            case ({rd_valid, out_exec})
                2'b10:   out_count <= out_count + 3'd1;
                2'b01:   out_count <= out_count - 3'd1;
                default: out_count <= out_count;
            endcase
        end
    end

endmodule

// File: tb/tb_sync_wstage_fifo.sv
// tb_sync_wstage_fifo
// -------------------
// Directed and randomized bench for sync_wstage_fifo with default parameters
// (8-bit data, 256 words). Inputs are driven and outputs sampled 1 time unit
// after each rising edge; expected data comes from a queue model.
module tb_sync_wstage_fifo;

    localparam int DW    = 8;
    localparam int DEPTH = 256;

    logic         clk = 1'b0;
    logic         rstn;
    logic [DW-1:0] in_data;
    logic         in_valid;
    logic         in_ready;
    logic [DW-1:0] out_data;
    logic         out_valid;
    logic         out_ready;
    logic         clear;
    logic [8:0]   count;

    int total = 0;
    int bad   = 0;
    logic [7:0] exp_q[$];

    always #5 clk = ~clk;

    sync_wstage_fifo #(.DATA_WIDTH(DW), .FIFO_DEPTH(DEPTH)) dut (
        .clk       (clk),
        .rstn      (rstn),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .clear     (clear),
        .count     (count)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rstn      = 1'b0;
        clear     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        in_data   = '0;
        tick();
        tick();
        rstn = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready got=%b want=1", in_ready); end
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%b want=0", out_valid); end
        total++; if (count !== 9'd0) begin bad++; $display("FAIL reset_count got=%0d want=0", count); end
        repeat (3) tick();
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_idle_out_valid got=%b want=0", out_valid); end
    endtask

    // Cycle 0 accept, out_valid first seen in cycle 4.
    task automatic test_single_word();
        do_reset();
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_data   = 8'hA5;
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL single_in_ready got=%b want=1", in_ready); end
        tick();
        in_valid = 1'b0;
        for (int c = 1; c <= 3; c++) begin
            total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL single_early_valid cycle=%0d got=%b want=0", c, out_valid); end
            total++; if (count !== 9'd1) begin bad++; $display("FAIL single_count cycle=%0d got=%0d want=1", c, count); end
            tick();
        end
        total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL single_valid_c4 got=%b want=1", out_valid); end
        total++; if (out_data !== 8'hA5) begin bad++; $display("FAIL single_data got=%h want=a5", out_data); end
        total++; if (count !== 9'd1) begin bad++; $display("FAIL single_count_c4 got=%0d want=1", count); end
        tick();
        out_ready = 1'b0;
        total++; if (count !== 9'd0) begin bad++; $display("FAIL single_count_after got=%0d want=0", count); end
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL single_valid_after got=%b want=0", out_valid); end
    endtask

    task automatic test_fill_drain();
        int idx;
        int cyc;
        do_reset();
        out_ready = 1'b0;
        for (int i = 0; i < 256; i++) begin
            in_valid = 1'b1;
            in_data  = 8'(i);
            total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL fill_in_ready word=%0d got=%b want=1", i, in_ready); end
            tick();
        end
        in_valid = 1'b0;
        total++; if (count !== 9'd256) begin bad++; $display("FAIL fill_count got=%0d want=256", count); end
        total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL fill_in_ready_full got=%b want=0", in_ready); end
        repeat (10) tick();
        total++; if (count !== 9'd256) begin bad++; $display("FAIL fill_count_hold got=%0d want=256", count); end
        out_ready = 1'b1;
        idx = 0;
        cyc = 0;
        while (idx < 256 && cyc < 3000) begin
            if (out_valid === 1'b1) begin
                total++; if (out_data !== 8'(idx)) begin bad++; $display("FAIL drain_data idx=%0d got=%h want=%h", idx, out_data, 8'(idx)); end
                idx++;
            end
            tick();
            cyc++;
        end
        out_ready = 1'b0;
        total++; if (idx != 256) begin bad++; $display("FAIL drain_timeout got=%0d words want=256", idx); end
        total++; if (count !== 9'd0) begin bad++; $display("FAIL drain_count got=%0d want=0", count); end
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL drain_out_valid got=%b want=0", out_valid); end
    endtask

    // Continues from the pointer state left by fill/drain so rounds cross
    // the RAM address wrap.
    task automatic test_wrap();
        int idx;
        int cyc;
        for (int r = 0; r < 3; r++) begin
            out_ready = 1'b0;
            for (int i = 0; i < 200; i++) begin
                in_valid = 1'b1;
                in_data  = 8'(r * 200 + i);
                total++; if (count !== 9'(i)) begin bad++; $display("FAIL wrap_count round=%0d got=%0d want=%0d", r, count, i); end
                tick();
            end
            in_valid = 1'b0;
            total++; if (count !== 9'd200) begin bad++; $display("FAIL wrap_count_full round=%0d got=%0d want=200", r, count); end
            out_ready = 1'b1;
            idx = 0;
            cyc = 0;
            while (idx < 200 && cyc < 2000) begin
                if (out_valid === 1'b1) begin
                    total++; if (out_data !== 8'(r * 200 + idx)) begin bad++; $display("FAIL wrap_data round=%0d idx=%0d got=%h want=%h", r, idx, out_data, 8'(r * 200 + idx)); end
                    idx++;
                end
                tick();
                cyc++;
            end
            out_ready = 1'b0;
            total++; if (idx != 200) begin bad++; $display("FAIL wrap_timeout round=%0d got=%0d want=200", r, idx); end
            total++; if (count !== 9'd0) begin bad++; $display("FAIL wrap_count_end round=%0d got=%0d want=0", r, count); end
        end
    endtask

    task automatic test_random();
        int   pushed;
        int   cyc;
        logic ie;
        logic oe;
        logic hold;
        logic [7:0] hold_data;
        do_reset();
        exp_q.delete();
        pushed    = 0;
        cyc       = 0;
        hold      = 1'b0;
        hold_data = '0;
        while ((pushed < 10000 || exp_q.size() != 0) && cyc < 40000) begin
            in_valid  = (pushed < 10000) && ($urandom_range(0, 1) == 1);
            in_data   = 8'($urandom);
            out_ready = ($urandom_range(0, 1) == 1);
            total++; if (count !== 9'(exp_q.size())) begin bad++; $display("FAIL rand_count cycle=%0d got=%0d want=%0d", cyc, count, exp_q.size()); end
            total++; if (in_ready !== (exp_q.size() < DEPTH)) begin bad++; $display("FAIL rand_in_ready cycle=%0d got=%b want=%b", cyc, in_ready, exp_q.size() < DEPTH); end
            if (out_valid === 1'b1) begin
                total++;
                if (exp_q.size() == 0) begin
                    bad++; $display("FAIL rand_spurious cycle=%0d got=%h want=no word", cyc, out_data);
                end else if (out_data !== exp_q[0]) begin
                    bad++; $display("FAIL rand_data cycle=%0d got=%h want=%h", cyc, out_data, exp_q[0]);
                end
            end
            if (hold) begin
                total++; if (out_valid !== 1'b1 || out_data !== hold_data) begin bad++; $display("FAIL rand_stable cycle=%0d got=%b/%h want=1/%h", cyc, out_valid, out_data, hold_data); end
            end
            ie        = in_valid & in_ready;
            oe        = out_valid & out_ready;
            hold      = out_valid & ~out_ready;
            hold_data = out_data;
            if (oe && exp_q.size() != 0) begin
                void'(exp_q.pop_front());
            end
            if (ie) begin
                exp_q.push_back(in_data);
                pushed++;
            end
            tick();
            cyc++;
        end
        in_valid  = 1'b0;
        out_ready = 1'b0;
        total++; if (exp_q.size() != 0 || pushed != 10000) begin bad++; $display("FAIL rand_timeout got=%0d pushed %0d left want=10000 pushed 0 left", pushed, exp_q.size()); end
        total++; if (count !== 9'd0) begin bad++; $display("FAIL rand_count_end got=%0d want=0", count); end
    endtask

    // Two clear timings: one on the edge that issues a read, one while the
    // read data is arriving.
    task automatic test_clear();
        int cyc;
        for (int off = 0; off < 2; off++) begin
            do_reset();
            out_ready = 1'b0;
            for (int i = 0; i < 10; i++) begin
                in_valid = 1'b1;
                in_data  = 8'(8'h10 + i);
                tick();
            end
            in_valid = 1'b0;
            repeat (6) tick();
            out_ready = 1'b1;
            repeat (off + 1) tick();
            clear = 1'b1;
            tick();
            clear = 1'b0;
            total++; if (count !== 9'd0) begin bad++; $display("FAIL clear_count off=%0d got=%0d want=0", off, count); end
            total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL clear_out_valid off=%0d got=%b want=0", off, out_valid); end
            total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL clear_in_ready off=%0d got=%b want=1", off, in_ready); end
            for (int c = 0; c < 8; c++) begin
                total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL clear_stale off=%0d cycle=%0d got=%b/%h want=0", off, c, out_valid, out_data); end
                tick();
            end
            in_valid = 1'b1;
            in_data  = 8'h3C;
            tick();
            in_valid = 1'b0;
            cyc = 0;
            while (out_valid !== 1'b1 && cyc < 20) begin
                tick();
                cyc++;
            end
            total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL clear_new_timeout off=%0d got=%b want=1", off, out_valid); end
            total++; if (out_data !== 8'h3C) begin bad++; $display("FAIL clear_new_data off=%0d got=%h want=3c", off, out_data); end
            tick();
            for (int c = 0; c < 6; c++) begin
                total++; if (out_valid !== 1'b0 || count !== 9'd0) begin bad++; $display("FAIL clear_after off=%0d cycle=%0d got=%b/%0d want=0/0", off, c, out_valid, count); end
                tick();
            end
            out_ready = 1'b0;
        end
    endtask

    task automatic test_full_boundary();
        int idx;
        int cyc;
        logic [7:0] want;
        do_reset();
        out_ready = 1'b0;
        for (int i = 0; i < 256; i++) begin
            in_valid = 1'b1;
            in_data  = 8'(i);
            tick();
        end
        in_valid = 1'b0;
        repeat (10) tick();
        total++; if (count !== 9'd256) begin bad++; $display("FAIL full_count got=%0d want=256", count); end
        total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL full_in_ready got=%b want=0", in_ready); end
        total++; if (out_valid !== 1'b1 || out_data !== 8'h00) begin bad++; $display("FAIL full_head got=%b/%h want=1/00", out_valid, out_data); end
        // Cycle t: read while full; the offered write must be refused.
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_data   = 8'h77;
        tick();
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL full_t1_in_ready got=%b want=1", in_ready); end
        total++; if (count !== 9'd255) begin bad++; $display("FAIL full_t1_count got=%0d want=255", count); end
        out_ready = 1'b0;
        tick();
        in_valid = 1'b0;
        total++; if (count !== 9'd256) begin bad++; $display("FAIL full_t2_count got=%0d want=256", count); end
        total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL full_t2_in_ready got=%b want=0", in_ready); end
        out_ready = 1'b1;
        idx = 0;
        cyc = 0;
        while (idx < 256 && cyc < 3000) begin
            if (out_valid === 1'b1) begin
                want = (idx < 255) ? 8'(idx + 1) : 8'h77;
                total++; if (out_data !== want) begin bad++; $display("FAIL full_drain idx=%0d got=%h want=%h", idx, out_data, want); end
                idx++;
            end
            tick();
            cyc++;
        end
        out_ready = 1'b0;
        total++; if (idx != 256) begin bad++; $display("FAIL full_drain_timeout got=%0d want=256", idx); end
        total++; if (count !== 9'd0 || out_valid !== 1'b0) begin bad++; $display("FAIL full_end got=%0d/%b want=0/0", count, out_valid); end
    endtask

    initial begin
        rstn      = 1'b0;
        clear     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        in_data   = '0;
        test_reset();
        test_single_word();
        test_fill_drain();
        test_wrap();
        test_clear();
        test_full_boundary();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
